spatz_tcdm_bank_xbar: RTL and testbench

SPATZ_TCDM_BANK_XBAR -- requirements
Module: spatz_tcdm_bank_xbar

---
 rtl/spatz_tcdm_bank_xbar.sv | 206 ++++++++++++++++++++
 tb/tb_spatz_tcdm_bank_xbar.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spatz_tcdm_bank_xbar.sv
// Request crossbar from NumInp requestors onto NumOut word-interleaved TCDM banks.
// Each bank has its own round-robin arbiter. A grant is locked while the bank stalls.
// Each input keeps a fixed-latency response tracker, and a saturating counter records conflict cycles.

// Per-bank round-robin arbiter with lock-in while the bank back-pressures.
module spatz_tcdm_bank_arb #(
  parameter int NumInp = 4,
  parameter int IdxW   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumInp-1:0] req,
  input  logic              ready,
  output logic              valid,
  output logic [IdxW-1:0]   idx
);
  logic [IdxW-1:0] ptr_q, lock_idx_q, rr_idx, next_ptr;
  logic            lock_q, rr_found, lock_hit;

  // Lowest requester at or above the pointer wins; otherwise the lowest one below it.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = NumInp-1; k >= 0; k--)
      if (req[k] && (k < int'(ptr_q))) begin
        rr_found = 1'b1;
        rr_idx   = IdxW'(k);
      end
    for (int k = NumInp-1; k >= 0; k--)
      if (req[k] && (k >= int'(ptr_q))) begin
        rr_found = 1'b1;
        rr_idx   = IdxW'(k);
      end
  end

  assign lock_hit = lock_q & req[lock_idx_q];
  assign valid    = lock_hit | rr_found;
  assign idx      = lock_hit ? lock_idx_q : rr_idx;
  assign next_ptr = (int'(idx) == NumInp-1) ? '0 : idx + 1'b1;

  // On acceptance, move the pointer past the winner. On a stall, pin the grant on the winner.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (valid) begin
      if (ready) begin
        ptr_q  <= next_ptr;
        lock_q <= 1'b0;
      end else begin
        lock_q     <= 1'b1;
        lock_idx_q <= idx;
      end
    end else begin
      lock_q <= 1'b0;
    end
  end
endmodule

module spatz_tcdm_bank_xbar #(
  parameter int NumInp        = 4,
  parameter int NumOut        = 8,
  parameter int AddrWidth     = 32,
  parameter int MemAddrWidth  = 10,
  parameter int DataWidth     = 32,
  parameter int MemRspLatency = 1,
  parameter int ScrambleMode  = 1,
  parameter int RspReg        = 0,
  localparam int StrbWidth    = DataWidth/8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumInp-1:0]                      req_valid_i,
  output logic [NumInp-1:0]                      req_ready_o,
  input  logic [NumInp-1:0][AddrWidth-1:0]       req_addr_i,
  input  logic [NumInp-1:0]                      req_write_i,
  input  logic [NumInp-1:0][DataWidth-1:0]       req_wdata_i,
  input  logic [NumInp-1:0][StrbWidth-1:0]       req_strb_i,
  output logic [NumInp-1:0]                      rsp_valid_o,
  output logic [NumInp-1:0][DataWidth-1:0]       rsp_rdata_o,
  output logic [NumOut-1:0]                      mem_valid_o,
  input  logic [NumOut-1:0]                      mem_ready_i,
  output logic [NumOut-1:0][MemAddrWidth-1:0]    mem_addr_o,
  output logic [NumOut-1:0]                      mem_write_o,
  output logic [NumOut-1:0][DataWidth-1:0]       mem_wdata_o,
  output logic [NumOut-1:0][StrbWidth-1:0]       mem_strb_o,
  input  logic [NumOut-1:0][DataWidth-1:0]       mem_rdata_i,
  input  logic                                   clear_i,
  output logic [31:0]                            conflict_cnt_o
);
  localparam int B    = $clog2(StrbWidth);
  localparam int S    = $clog2(NumOut);
  localparam int IdxW = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam int RowW = AddrWidth - B - S;
  localparam int L    = MemRspLatency;

  logic [NumInp-1:0][S-1:0]            bank;
  logic [NumInp-1:0][MemAddrWidth-1:0] maddr;
  logic [NumInp-1:0]                   granted, accept;
  logic [NumOut-1:0][NumInp-1:0]       tgt;
  logic [NumOut-1:0]                   arb_valid;
  logic [NumOut-1:0][IdxW-1:0]         arb_idx;

  // Per-input address decode: raw bank, row, and scrambled bank.
  for (genvar i = 0; i < NumInp; i++) begin : g_dec
    logic [S-1:0]    raw;
    logic [RowW-1:0] row;
    assign raw      = req_addr_i[i][B +: S];
    assign row      = req_addr_i[i][AddrWidth-1:B+S];
    assign maddr[i] = row[MemAddrWidth-1:0];
    if (ScrambleMode == 1) begin : g_half
      assign bank[i] = (row[1] ^ row[0]) ? raw + S'(NumOut/2) : raw;
    end else if (ScrambleMode == 2) begin : g_rot
      assign bank[i] = raw + row[S-1:0];
    end else begin : g_none
      assign bank[i] = raw;
    end
  end

  // Per-bank arbitration and payload mux.
  for (genvar b = 0; b < NumOut; b++) begin : g_bank
    for (genvar i = 0; i < NumInp; i++) begin : g_tgt
      assign tgt[b][i] = req_valid_i[i] & (bank[i] == S'(b));
    end
    spatz_tcdm_bank_arb #(.NumInp(NumInp), .IdxW(IdxW)) u_arb (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .req   (tgt[b]),
      .ready (mem_ready_i[b]),
      .valid (arb_valid[b]),
      .idx   (arb_idx[b])
    );
    assign mem_valid_o[b] = arb_valid[b] & rst_ni;
    assign mem_addr_o[b]  = maddr[arb_idx[b]];
    assign mem_write_o[b] = req_write_i[arb_idx[b]];
    assign mem_wdata_o[b] = req_wdata_i[arb_idx[b]];
    assign mem_strb_o[b]  = req_strb_i[arb_idx[b]];
  end

  // Ready is combinational: the input owns its bank's grant and the bank is ready.
  for (genvar i = 0; i < NumInp; i++) begin : g_rdy
    assign granted[i]     = req_valid_i[i] & mem_valid_o[bank[i]] & (arb_idx[bank[i]] == IdxW'(i));
    assign req_ready_o[i] = granted[i] & mem_ready_i[bank[i]];
    assign accept[i]      = req_valid_i[i] & req_ready_o[i];
  end

  logic [NumInp-1:0][L-1:0]        vld_pipe;
  logic [NumInp-1:0][L-1:0][S-1:0] bank_pipe;
  logic [NumInp-1:0]               rsp_v;
  logic [NumInp-1:0][DataWidth-1:0] rsp_d;

  // Track which bank each accepted request went to, aligned with the fixed bank latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe  <= '0;
      bank_pipe <= '0;
    end else begin
      for (int i = 0; i < NumInp; i++) begin
        vld_pipe[i][0]  <= accept[i];
        bank_pipe[i][0] <= bank[i];
        for (int s = 1; s < L; s++) begin
          vld_pipe[i][s]  <= vld_pipe[i][s-1];
          bank_pipe[i][s] <= bank_pipe[i][s-1];
        end
      end
    end
  end

  for (genvar i = 0; i < NumInp; i++) begin : g_rsp
    assign rsp_v[i] = vld_pipe[i][L-1];
    assign rsp_d[i] = mem_rdata_i[bank_pipe[i][L-1]];
  end

  if (RspReg != 0) begin : g_rsp_reg
    logic [NumInp-1:0]                rsp_v_q;
    logic [NumInp-1:0][DataWidth-1:0] rsp_d_q;
    // Optional output register on the response path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rsp_v_q <= '0;
        rsp_d_q <= '0;
      end else begin
        rsp_v_q <= rsp_v;
        rsp_d_q <= rsp_d;
      end
    end
    assign rsp_valid_o = rsp_v_q;
    assign rsp_rdata_o = rsp_d_q;
  end else begin : g_rsp_comb
    assign rsp_valid_o = rsp_v;
    assign rsp_rdata_o = rsp_d;
  end

  logic [31:0] cnt_q;
  logic        stall;
  assign stall          = |(req_valid_i & ~req_ready_o);
  assign conflict_cnt_o = cnt_q;

  // Count cycles with any stalled requester. The count saturates, and clear wins over an increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  cnt_q <= '0;
    else if (clear_i)             cnt_q <= '0;
    else if (stall && cnt_q != '1) cnt_q <= cnt_q + 32'd1;
  end
endmodule

// File: tb/tb_spatz_tcdm_bank_xbar.sv
// Directed bench for spatz_tcdm_bank_xbar. Half-row-swap and row-rotate instances share the inputs.
// The mode-1 responses are scoreboarded.
module tb_spatz_tcdm_bank_xbar;
  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic [3:0]       req_valid, req_write;
  logic [3:0][31:0] req_addr, req_wdata;
  logic [3:0][3:0]  req_strb;
  logic [7:0]       mem_ready;
  logic [7:0][31:0] mem_rdata;

  logic [3:0]       req_ready, rsp_valid, m2_req_ready, m2_rsp_valid;
  logic [3:0][31:0] rsp_rdata, m2_rsp_rdata;
  logic [7:0]       mem_valid, mem_write, m2_mem_valid, m2_mem_write;
  logic [7:0][9:0]  mem_addr, m2_mem_addr;
  logic [7:0][31:0] mem_wdata, m2_mem_wdata;
  logic [7:0][3:0]  mem_strb, m2_mem_strb;
  logic [31:0]      cnt, m2_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct { int port; logic [31:0] data; int due; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  spatz_tcdm_bank_xbar #(.ScrambleMode(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_write_i(req_write), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .mem_valid_o(mem_valid), .mem_ready_i(mem_ready),
    .mem_addr_o(mem_addr), .mem_write_o(mem_write), .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb),
    .mem_rdata_i(mem_rdata), .clear_i(clear), .conflict_cnt_o(cnt));

  spatz_tcdm_bank_xbar #(.ScrambleMode(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(m2_req_ready),
    .req_addr_i(req_addr), .req_write_i(req_write), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(m2_rsp_valid), .rsp_rdata_o(m2_rsp_rdata), .mem_valid_o(m2_mem_valid), .mem_ready_i(mem_ready),
    .mem_addr_o(m2_mem_addr), .mem_write_o(m2_mem_write), .mem_wdata_o(m2_mem_wdata), .mem_strb_o(m2_mem_strb),
    .mem_rdata_i(mem_rdata), .clear_i(clear), .conflict_cnt_o(m2_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    tests++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Mode-1 bank mapping: swap half the banks on rows 1 and 2 of every group of four rows.
  function automatic int bank_m1(input logic [31:0] a);
    int raw, row;
    raw = int'((a >> 2) & 32'h7);
    row = int'((a >> 5) & 32'h3);
    if (row == 1 || row == 2) raw = (raw + 4) % 8;
    return raw;
  endfunction

  // Scoreboard: check responses that are due now, then queue new acceptances for the next cycle.
  always @(negedge clk) begin
    logic ev;
    logic [31:0] ed;
    if (!rst_n) begin
      sb.delete();
      chk("rsp_valid_in_reset", {28'd0, rsp_valid}, 32'd0);
    end else begin
      for (int p = 0; p < 4; p++) begin
        ev = 1'b0;
        ed = '0;
        foreach (sb[k]) if (sb[k].port == p && sb[k].due == cyc) begin ev = 1'b1; ed = sb[k].data; end
        chk($sformatf("rsp_valid[%0d]", p), {31'd0, rsp_valid[p]}, {31'd0, ev});
        if (ev) chk($sformatf("rsp_rdata[%0d]", p), rsp_rdata[p], ed);
      end
      for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].due <= cyc) sb.delete(k);
      for (int p = 0; p < 4; p++)
        if (req_valid[p] && req_ready[p])
          sb.push_back('{p, mem_rdata[bank_m1(req_addr[p])], cyc + 1});
    end
  end

  initial begin
    for (int b = 0; b < 8; b++) mem_rdata[b] = 32'hDA7A_0000 + 32'(b) * 32'h111;
    rst_n = 1'b0; clear = 1'b0; mem_ready = 8'hFF;
    req_valid = 4'hF; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;

    // Reset state: no bank requests even with every requestor valid.
    smp();
    chk("rst_mem_valid", {24'd0, mem_valid}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    tick(); tick();
    rst_n = 1'b1; req_valid = '0;

    // Mode 1 read of 0x24: bank 5, word 1.
    tick();
    req_addr[0] = 32'h24; req_valid = 4'b0001;
    smp();
    chk("m1_ready", {28'd0, req_ready}, 32'h1);
    chk("m1_mem_valid", {24'd0, mem_valid}, 32'h20);
    chk("m1_mem_addr5", {22'd0, mem_addr[5]}, 32'd1);
    tick(); req_valid = '0;
    smp();
    chk("m1_rsp_data", rsp_rdata[0], 32'hDA7A_0555);

    // Ports 0 and 2 collide on bank 0.
    tick();
    req_addr[0] = 32'h0; req_addr[2] = 32'h0; req_valid = 4'b0101;
    smp(); chk("rr_c0_ready", {28'd0, req_ready}, 32'h1);
    tick(); req_valid = 4'b0100;
    smp(); chk("rr_c1_ready", {28'd0, req_ready}, 32'h4);
    chk("rr_cnt1", cnt, 32'd1);
    // The pointer now sits at 3, so port 3 beats port 0.
    tick(); req_addr[3] = 32'h0; req_valid = 4'b1001;
    smp(); chk("rr_ptr3_ready", {28'd0, req_ready}, 32'h8);
    tick(); req_valid = 4'b0001;
    smp(); chk("rr_port0_ready", {28'd0, req_ready}, 32'h1);
    chk("rr_cnt2", cnt, 32'd2);
    tick(); req_valid = '0;

    // Fresh reset, then hold bank 0 not-ready for three cycles with ports 0 and 1 contending.
    rst_n = 1'b0; smp(); tick(); rst_n = 1'b1; smp(); tick();
    req_addr[0] = 32'h0;   req_write[0] = 1'b1; req_wdata[0] = 32'h1111_1111; req_strb[0] = 4'hF;
    req_addr[1] = 32'h100; req_write[1] = 1'b0; req_wdata[1] = 32'h2222_2222; req_strb[1] = 4'h0;
    req_valid = 4'b0011; mem_ready = 8'hFE;
    for (int c = 0; c < 3; c++) begin
      smp();
      chk($sformatf("lock_c%0d_ready", c), {28'd0, req_ready}, 32'h0);
      chk($sformatf("lock_c%0d_valid", c), {31'd0, mem_valid[0]}, 32'd1);
      chk($sformatf("lock_c%0d_addr", c), {22'd0, mem_addr[0]}, 32'd0);
      chk($sformatf("lock_c%0d_wdata", c), mem_wdata[0], 32'h1111_1111);
      chk($sformatf("lock_c%0d_write", c), {31'd0, mem_write[0]}, 32'd1);
      tick();
    end
    mem_ready = 8'hFF;
    smp(); chk("lock_c3_ready", {28'd0, req_ready}, 32'h1);
    tick(); req_valid = 4'b0010;
    smp(); chk("lock_c4_ready", {28'd0, req_ready}, 32'h2);
    chk("lock_cnt4", cnt, 32'd4);
    chk("lock_port1_addr", {22'd0, mem_addr[0]}, 32'd8);
    tick(); req_valid = '0; req_write = '0;
    smp(); chk("lock_cnt_after", cnt, 32'd4);

    // Distinct banks in both modes: all four accepted together, and 0x7C lands on bank 2 in mode 2.
    tick();
    req_addr[0] = 32'h7C; req_addr[1] = 32'h0; req_addr[2] = 32'h4; req_addr[3] = 32'hC;
    req_valid = 4'hF;
    smp();
    chk("m2_ready_all", {28'd0, m2_req_ready}, 32'hF);
    chk("m1_ready_all", {28'd0, req_ready}, 32'hF);
    chk("m2_mem_valid", {24'd0, m2_mem_valid}, 32'h0F);
    chk("m2_mem_addr2", {22'd0, m2_mem_addr[2]}, 32'd3);
    chk("m1_mem_valid_all", {24'd0, mem_valid}, 32'h8B);
    tick(); req_valid = '0;
    smp();

    // Reset the cycle after an acceptance: the in-flight response must be dropped.
    tick(); req_addr[1] = 32'h8; req_valid = 4'b0010;
    smp(); chk("rst_acc_ready", {28'd0, req_ready}, 32'h2);
    tick(); req_valid = '0; rst_n = 1'b0;
    smp();
    chk("rst_inflight_cnt", cnt, 32'd0);
    chk("rst_inflight_memv", {24'd0, mem_valid}, 32'd0);
    tick(); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      smp(); chk($sformatf("rst_norsp_%0d", c), {28'd0, rsp_valid}, 32'd0);
      tick();
    end
    chk("rst_release_cnt", cnt, 32'd0);

    // Saturation with a held conflict, then clear takes priority over an increment.
    req_addr[0] = 32'h0; req_addr[1] = 32'h100; req_valid = 4'b0011; mem_ready = 8'hFE;
    smp();
    force dut1.cnt_q = 32'hFFFF_FFFD;
    #1 release dut1.cnt_q;
    tick(); tick(); tick();
    smp(); chk("sat_max", cnt, 32'hFFFF_FFFF);
    tick();
    smp(); chk("sat_hold", cnt, 32'hFFFF_FFFF);
    tick(); clear = 1'b1;
    smp();
    tick(); clear = 1'b0;
    smp(); chk("clear_prio", cnt, 32'd0);
    tick();
    smp(); chk("clear_then_inc", cnt, 32'd1);
    tick(); req_valid = '0;
    mem_ready = 8'hFF;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
